// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MEM->WB write-back stage.
//   - Default field widths of a write-back entry.
//   - wb_payload_t: one write-back entry at the default widths.
//   - REG_ZERO: index of the hard-wired zero register (never written).
//   - payload_w(): packed width of an entry for arbitrary field widths, so
//     parametrised instances can size their flat payload vector.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_RD_W   = 5;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_DATA_W-1:0] dm;
    logic [DEF_ADDR_W-1:0] dmaddr;
    logic [DEF_RD_W-1:0]   rd;
    logic                  regw;
    logic                  mem2r;
  } wb_payload_t;

  // Field order matches wb_payload_t: alu, dm, dmaddr, rd, regw, mem2r.
  function automatic int payload_w(input int data_w, input int addr_w, input int rd_w);
    return 2 * data_w + addr_w + rd_w + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic 2-entry valid/ready skid register on a packed payload of width W.
// The main register drives the output; the skid register catches the one
// entry that can arrive while main is stalled. in_ready is taken straight
// from skid state, so there is no combinational path from in_valid or
// out_ready to in_ready.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake
//   in_data [W]       upstream payload
//   flush             synchronous kill of both held entries
//   out_valid/out_ready downstream handshake
//   out_data [W]      main-register payload
// -----------------------------------------------------------------------------
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_main_vld_p1;
  logic         r_skid_vld_p1;
  logic [W-1:0] r_main_data_p1;
  logic [W-1:0] r_skid_data_p1;

  logic w_acc;
  logic w_xfer;
  logic w_main_free;

  // Skid empty is the only condition for accepting; it is registered state.
  assign w_acc       = in_valid & ~r_skid_vld_p1;
  assign w_xfer      = r_main_vld_p1 & out_ready;
  assign w_main_free = ~r_main_vld_p1 | w_xfer;

  // ---- stage p1: main + skid registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld_p1  <= 1'b0;
      r_skid_vld_p1  <= 1'b0;
      r_main_data_p1 <= '0;
      r_skid_data_p1 <= '0;
    end else if (flush) begin
      // Payloads are left stale; they are don't-care while invalid.
      r_main_vld_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_main_free) begin
      // Skid entry is older than anything upstream, so it refills main first.
      // While skid is full, w_acc is 0, so no input can be lost here.
      if (r_skid_vld_p1) begin
        r_main_data_p1 <= r_skid_data_p1;
        r_main_vld_p1  <= 1'b1;
        r_skid_vld_p1  <= 1'b0;
      end else if (w_acc) begin
        r_main_data_p1 <= in_data;
        r_main_vld_p1  <= 1'b1;
      end else begin
        r_main_vld_p1 <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid_data_p1 <= in_data;
      r_skid_vld_p1  <= 1'b1;
    end
  end

  assign in_ready  = ~r_skid_vld_p1;
  assign out_valid = r_main_vld_p1;
  assign out_data  = r_main_data_p1;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_stage
// MEM->WB pipeline stage between data memory and the register file. Holds up
// to two entries in a skid buffer, selects the write-back data, gates the
// register-file write enable and counts idle (bubble) cycles.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready registered)
//   in_alu, in_dm             ALU result, DM read data        [DATA_W]
//   in_dmaddr                 DM address                      [ADDR_W]
//   in_rd                     destination register            [RD_W]
//   in_regw, in_mem2r         write request, DM/ALU select
//   flush                     synchronous kill of held entries
//   out_valid / out_ready     downstream handshake
//   out_alu .. out_mem2r      held fields of the main register
//   wb_data                   out_mem2r ? out_dm : out_alu
//   wb_we                     RF write enable, never for rd==0
//   bubble_cnt                saturating count of cycles with out_valid==0
// -----------------------------------------------------------------------------
module mem_wb_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_dm,
  input  logic [ADDR_W-1:0] in_dmaddr,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regw,
  input  logic              in_mem2r,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_dm,
  output logic [ADDR_W-1:0] out_dmaddr,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regw,
  output logic              out_mem2r,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int PW = payload_w(DATA_W, ADDR_W, RD_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PW-1:0]    w_in_pl;
  logic [PW-1:0]    w_out_pl;
  logic             w_out_valid;
  logic [CNT_W-1:0] r_bubble_p1;

  assign w_in_pl = {in_alu, in_dm, in_dmaddr, in_rd, in_regw, in_mem2r};

  pipe_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_pl),
    .flush     (flush),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_pl)
  );

  assign {out_alu, out_dm, out_dmaddr, out_rd, out_regw, out_mem2r} = w_out_pl;
  assign out_valid = w_out_valid;

  assign wb_data = out_mem2r ? out_dm : out_alu;
  // A transfer that coincides with flush still writes back.
  assign wb_we   = w_out_valid & out_ready & out_regw & (out_rd != RD_W'(REG_ZERO));

  // ---- stage p1: bubble counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_p1 <= '0;
    end else if (!w_out_valid) begin
      r_bubble_p1 <= sat_inc(r_bubble_p1);
    end
  end

  assign bubble_cnt = r_bubble_p1;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
module tb_mem_wb_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu;
  logic [31:0] in_dm;
  logic [9:0]  in_dmaddr;
  logic [4:0]  in_rd;
  logic        in_regw;
  logic        in_mem2r;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu;
  logic [31:0] out_dm;
  logic [9:0]  out_dmaddr;
  logic [4:0]  out_rd;
  logic        out_regw;
  logic        out_mem2r;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [3:0]  bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(
    .DATA_W (32),
    .ADDR_W (10),
    .RD_W   (5),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu     (in_alu),
    .in_dm      (in_dm),
    .in_dmaddr  (in_dmaddr),
    .in_rd      (in_rd),
    .in_regw    (in_regw),
    .in_mem2r   (in_mem2r),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_alu    (out_alu),
    .out_dm     (out_dm),
    .out_dmaddr (out_dmaddr),
    .out_rd     (out_rd),
    .out_regw   (out_regw),
    .out_mem2r  (out_mem2r),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct {
    logic        vld;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [4:0]  rd;
    logic        regw;
    logic        m2r;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_wd;
    logic        e_we;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic vld, input logic [31:0] alu, input logic [31:0] dm,
                      input logic [4:0] rd, input logic regw, input logic m2r,
                      input logic fl, input logic ordy, input logic e_ov,
                      input logic e_ir, input logic [31:0] e_wd, input logic e_we);
    vec_t v;
    v.vld = vld; v.alu = alu; v.dm = dm; v.rd = rd; v.regw = regw; v.m2r = m2r;
    v.fl = fl; v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir; v.e_wd = e_wd; v.e_we = e_we;
    vq.push_back(v);
  endtask

  task automatic drive(input logic vld, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [4:0] rd, input logic regw, input logic m2r,
                       input logic fl, input logic ordy);
    in_valid  = vld;
    in_alu    = alu;
    in_dm     = dm;
    in_dmaddr = alu[9:0];
    in_rd     = rd;
    in_regw   = regw;
    in_mem2r  = m2r;
    flush     = fl;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stimulus table: vld alu dm rd regw m2r flush ordy | out_valid in_ready wb_data wb_we
    // Streaming four entries
    addv(1, 32'h10, 0, 1, 1, 0, 0, 1,  0, 1, 32'h0,  0);
    addv(1, 32'h11, 0, 2, 1, 0, 0, 1,  1, 1, 32'h10, 1);
    addv(1, 32'h12, 0, 3, 1, 0, 0, 1,  1, 1, 32'h11, 1);
    addv(1, 32'h13, 0, 4, 1, 0, 0, 1,  1, 1, 32'h12, 1);
    addv(0, 32'h0,  0, 0, 0, 0, 0, 1,  1, 1, 32'h13, 1);
    addv(0, 32'h0,  0, 0, 0, 0, 0, 1,  0, 1, 32'h0,  0);
    // Backpressure: A, then B into skid, C held upstream
    addv(1, 32'h20, 0, 5, 1, 0, 0, 1,  0, 1, 32'h0,  0);
    addv(1, 32'h21, 0, 6, 1, 0, 0, 0,  1, 1, 32'h20, 0);
    addv(1, 32'h22, 0, 7, 1, 0, 0, 0,  1, 0, 32'h20, 0);
    addv(1, 32'h22, 0, 7, 1, 0, 0, 1,  1, 0, 32'h20, 1);
    addv(1, 32'h22, 0, 7, 1, 0, 0, 1,  1, 1, 32'h21, 1);
    addv(0, 32'h0,  0, 0, 0, 0, 0, 1,  1, 1, 32'h22, 1);
    addv(0, 32'h0,  0, 0, 0, 0, 0, 1,  0, 1, 32'h0,  0);
    // Mux and write-enable gating
    addv(1, 32'h5,  32'hDEADBEEF, 8, 1, 1, 0, 1,  0, 1, 32'h0,        0);
    addv(1, 32'h77, 32'h1234,     0, 1, 0, 0, 1,  1, 1, 32'hDEADBEEF, 1);
    addv(1, 32'h99, 32'h0,        9, 0, 0, 0, 1,  1, 1, 32'h77,       0);
    addv(0, 32'h0,  32'h0,        0, 0, 0, 0, 1,  1, 1, 32'h99,       0);
    addv(0, 32'h0,  32'h0,        0, 0, 0, 0, 1,  0, 1, 32'h0,        0);
    // Flush with two entries held and input offered
    addv(1, 32'h30, 0, 10, 1, 0, 0, 0,  0, 1, 32'h0,  0);
    addv(1, 32'h31, 0, 11, 1, 0, 0, 0,  1, 1, 32'h30, 0);
    addv(1, 32'h32, 0, 12, 1, 0, 1, 0,  1, 0, 32'h30, 0);
    addv(0, 32'h0,  0, 0,  0, 0, 0, 1,  0, 1, 32'h0,  0);
    // Flush with a transfer completing and a simultaneous accept dropped
    addv(1, 32'h40, 0, 13, 1, 0, 0, 1,  0, 1, 32'h0,  0);
    addv(1, 32'h41, 0, 14, 1, 0, 1, 1,  1, 1, 32'h40, 1);
    addv(0, 32'h0,  0, 0,  0, 0, 0, 1,  0, 1, 32'h0,  0);
    addv(0, 32'h0,  0, 0,  0, 0, 0, 1,  0, 1, 32'h0,  0);

    // Reset state and saturating bubble counter
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst bubble_cnt", 32'(bubble_cnt), 32'd0);
    rst = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("bubble_cnt 14", 32'(bubble_cnt), 32'd14);
    @(posedge clk);
    #1;
    chk("bubble_cnt 15", 32'(bubble_cnt), 32'd15);
    repeat (5) @(posedge clk);
    #1;
    chk("bubble_cnt hold", 32'(bubble_cnt), 32'd15);

    // Table-driven cycles: inputs set after posedge, outputs checked at negedge
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].vld, vq[i].alu, vq[i].dm, vq[i].rd, vq[i].regw, vq[i].m2r,
            vq[i].fl, vq[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
      chk($sformatf("vec%0d wb_we", i), 32'(wb_we), 32'(vq[i].e_we));
      if (vq[i].e_ov)
        chk($sformatf("vec%0d wb_data", i), wb_data, vq[i].e_wd);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-stream with two entries held
    drive(1'b1, 32'h50, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 32'h51, 32'h0, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("held out_valid", 32'(out_valid), 32'd1);
    chk("held in_ready", 32'(in_ready), 32'd0);
    chk("held out_alu", out_alu, 32'h50);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("async rst out_alu", out_alu, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst out_valid", 32'(out_valid), 32'd0);
    chk("post rst bubble_cnt", 32'(bubble_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
